// File: rtl/casex_example.sv
// Registered casex-style pattern classifier with optional per-class hit counters.
// Define CASEX_EXAMPLE_HIT_COUNT_EN to compile in clr_cnt, cnt_a, cnt_b and cnt_none.
module casex_example #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       in,
    output logic [1:0]       out,
    output logic             out_valid
`ifdef CASEX_EXAMPLE_HIT_COUNT_EN
    ,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_none
`endif
);

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_A    = 2'b01;
    localparam logic [1:0] CODE_B    = 2'b10;

    logic       hit_a_c;
    logic       hit_b_c;
    logic [1:0] code_c;

    // Case-inequality keeps casex semantics: an X/Z input bit matches any pattern bit.
    // Class A = 1?00, class B = 01?0; A wins when both match.
    always_comb begin
        hit_a_c = (in[3] !== 1'b0) && (in[1] !== 1'b1) && (in[0] !== 1'b1);
        hit_b_c = (in[3] !== 1'b1) && (in[2] !== 1'b0) && (in[0] !== 1'b1);
        code_c  = CODE_NONE;
        if (hit_a_c) begin
            code_c = CODE_A;
        end else if (hit_b_c) begin
            code_c = CODE_B;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= CODE_NONE;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= code_c;
            end
        end
    end

`ifdef CASEX_EXAMPLE_HIT_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Saturating counters; clear beats a same-cycle increment, reset beats both.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            cnt_a    <= '0;
            cnt_b    <= '0;
            cnt_none <= '0;
        end else if (in_valid) begin
            case (code_c)
                CODE_A: if (cnt_a != CNT_MAX) cnt_a <= cnt_a + CNT_W'(1);
                CODE_B: if (cnt_b != CNT_MAX) cnt_b <= cnt_b + CNT_W'(1);
                default: if (cnt_none != CNT_MAX) cnt_none <= cnt_none + CNT_W'(1);
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_casex_example.sv
// Self-checking bench for casex_example; counter checks compile in with CASEX_EXAMPLE_HIT_COUNT_EN.
module tb_casex_example;

`ifdef CASEX_EXAMPLE_HIT_COUNT_EN
    localparam int unsigned CW = 2;
`else
    localparam int unsigned CW = 8;
`endif
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [3:0]    in;
    logic          clr_cnt;
    logic [1:0]    out;
    logic          out_valid;
`ifdef CASEX_EXAMPLE_HIT_COUNT_EN
    logic [CW-1:0] cnt_a;
    logic [CW-1:0] cnt_b;
    logic [CW-1:0] cnt_none;
`endif

    int total;
    int bad;

    // Reference state
    logic [1:0] eo;
    logic       ev;
    int         ea, eb, en;

    casex_example #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (in),
        .out       (out),
        .out_valid (out_valid)
`ifdef CASEX_EXAMPLE_HIT_COUNT_EN
        ,
        .clr_cnt   (clr_cnt),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b),
        .cnt_none  (cnt_none)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pattern strings read left to right as bits 3..0; '?' is don't-care, X/Z input matches anything.
    function automatic logic [1:0] ref_code(input logic [3:0] v);
        string pat[2];
        pat[0] = "1?00";
        pat[1] = "01?0";
        for (int k = 0; k < 2; k++) begin
            bit ok = 1'b1;
            for (int i = 0; i < 4; i++) begin
                byte  ch = pat[k][i];
                logic b  = v[3-i];
                if (ch != "?" && b !== 1'bx && b !== 1'bz) begin
                    if ((ch == "1") ? (b !== 1'b1) : (b !== 1'b0)) ok = 1'b0;
                end
            end
            if (ok) return (k == 0) ? 2'b01 : 2'b10;
        end
        return 2'b00;
    endfunction

    function automatic int sat_inc(input int c);
        return (c < CNT_MAX) ? c + 1 : c;
    endfunction

    // Drive one cycle, advance past the edge, and update the reference.
    task automatic step(input logic r, input logic v, input logic [3:0] d, input logic c);
        logic [1:0] code;
        rst      = r;
        in_valid = v;
        in       = d;
        clr_cnt  = c;
        code     = ref_code(in);
        @(posedge clk);
        #1;
        if (r) begin
            eo = 2'b00; ev = 1'b0; ea = 0; eb = 0; en = 0;
        end else begin
            ev = v;
            if (v) eo = code;
            if (c) begin
                ea = 0; eb = 0; en = 0;
            end else if (v) begin
                if (code == 2'b01)      ea = sat_inc(ea);
                else if (code == 2'b10) eb = sat_inc(eb);
                else                    en = sat_inc(en);
            end
        end
        rst = 1'b0; in_valid = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 4'b1000, 1'b0);
        total++;
        if ({out_valid, out} !== 3'b000) begin
            bad++;
            $display("FAIL reset_out: got v=%b out=%b want v=0 out=00", out_valid, out);
        end
`ifdef CASEX_EXAMPLE_HIT_COUNT_EN
        total++;
        if (cnt_a !== '0 || cnt_b !== '0 || cnt_none !== '0) begin
            bad++;
            $display("FAIL reset_cnt: got a=%0d b=%0d n=%0d want 0 0 0", cnt_a, cnt_b, cnt_none);
        end
`endif
    endtask

    task automatic test_known_sweep();
        logic [3:0] vin [5];
        logic [1:0] vexp[5];
        vin  = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b1111};
        vexp = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00};
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, vin[i], 1'b0);
            total++;
            if ({out_valid, out} !== {1'b1, vexp[i]}) begin
                bad++;
                $display("FAIL t1_sweep[%0d]: got v=%b out=%b want v=1 out=%b", i, out_valid, out, vexp[i]);
            end
        end
    endtask

    task automatic test_xz_inputs();
        logic [3:0] vin[3];
        vin = '{4'b1x00, 4'b01z0, 4'bx100};
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, vin[i], 1'b0);
            total++;
            if ({out_valid, out} !== {1'b1, eo}) begin
                bad++;
                $display("FAIL t2_xz[%0d]: got v=%b out=%b want v=1 out=%b", i, out_valid, out, eo);
            end
        end
    endtask

    task automatic test_hold();
        step(1'b0, 1'b1, 4'b0100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 4'b1000, 1'b0);
            total++;
            if ({out_valid, out} !== 3'b010) begin
                bad++;
                $display("FAIL t3_hold[%0d]: got v=%b out=%b want v=0 out=10", i, out_valid, out);
            end
`ifdef CASEX_EXAMPLE_HIT_COUNT_EN
            total++;
            if (cnt_a !== CW'(ea) || cnt_b !== CW'(eb) || cnt_none !== CW'(en)) begin
                bad++;
                $display("FAIL t3_cnt[%0d]: got a=%0d b=%0d n=%0d want %0d %0d %0d",
                         i, cnt_a, cnt_b, cnt_none, ea, eb, en);
            end
`endif
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b0, 1'b1, 4'b0110, 1'b0);
        step(1'b1, 1'b1, 4'b1000, 1'b0);
        total++;
        if ({out_valid, out} !== 3'b000) begin
            bad++;
            $display("FAIL t4_rst: got v=%b out=%b want v=0 out=00", out_valid, out);
        end
`ifdef CASEX_EXAMPLE_HIT_COUNT_EN
        total++;
        if (cnt_a !== '0 || cnt_b !== '0 || cnt_none !== '0) begin
            bad++;
            $display("FAIL t4_cnt: got a=%0d b=%0d n=%0d want 0 0 0", cnt_a, cnt_b, cnt_none);
        end
`endif
        step(1'b0, 1'b1, 4'b0110, 1'b0);
        total++;
        if ({out_valid, out} !== 3'b110) begin
            bad++;
            $display("FAIL t4_after: got v=%b out=%b want v=1 out=10", out_valid, out);
        end
    endtask

`ifdef CASEX_EXAMPLE_HIT_COUNT_EN
    task automatic test_saturation();
        int want[5];
        want = '{1, 2, 3, 3, 3};
        step(1'b1, 1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 4'b1000, 1'b0);
            total++;
            if (int'(cnt_a) !== want[i]) begin
                bad++;
                $display("FAIL t5_sat[%0d]: got cnt_a=%0d want %0d", i, cnt_a, want[i]);
            end
        end
        step(1'b0, 1'b1, 4'b1000, 1'b1);
        total++;
        if (cnt_a !== '0 || {out_valid, out} !== 3'b101) begin
            bad++;
            $display("FAIL t5_clr: got cnt_a=%0d v=%b out=%b want 0 1 01", cnt_a, out_valid, out);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic r, v, c;
            r = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 15) == 0);
            step(r, v, 4'($urandom), c);
            total++;
            if ({out_valid, out} !== {ev, eo}) begin
                bad++;
                $display("FAIL rand_out[%0d]: got v=%b out=%b want v=%b out=%b", i, out_valid, out, ev, eo);
            end
`ifdef CASEX_EXAMPLE_HIT_COUNT_EN
            total++;
            if (cnt_a !== CW'(ea) || cnt_b !== CW'(eb) || cnt_none !== CW'(en)) begin
                bad++;
                $display("FAIL rand_cnt[%0d]: got a=%0d b=%0d n=%0d want %0d %0d %0d",
                         i, cnt_a, cnt_b, cnt_none, ea, eb, en);
            end
`endif
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b0; in_valid = 1'b0; in = 4'b0000; clr_cnt = 1'b0;
        eo = 2'b00; ev = 1'b0; ea = 0; eb = 0; en = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_known_sweep();
        test_xz_inputs();
        test_hold();
        test_reset_midstream();
`ifdef CASEX_EXAMPLE_HIT_COUNT_EN
        test_saturation();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
